disp_scan: RTL and testbench

DISP_SCAN -- requirements
Module: disp_scan

---
 rtl/disp_scan.sv | 166 ++++++++++++++++
 tb/tb_disp_scan.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/disp_scan.sv
// disp_scan: multiplexed display scanner with blanking between digit slots.
//
// Each digit gets a slot of SLOT_CYCLES clocks. The first BLANK_CYCLES clocks
// of a slot keep all digit selects off. After that the digit is driven.
// New data is loaded into a pending buffer. It is moved into the display
// registers only at a frame boundary, or at once while idle, so a frame never
// shows a mix of old and new digits.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   enable          scan enable; low forces IDLE
//   load            one-cycle capture of data_in/dp_in into the pending buffer
//   data_in/dp_in   digit nibbles (digit k at [4k+3:4k]) and decimal points
//   nibble_out      registered nibble of the active digit
//   dp_out          registered decimal point of the active digit
//   digit_en        one-hot digit select (zero while blanking or idle)
//   load_ack        pulses the cycle after pending data is committed
//   frame_tick      pulses on the last cycle of the final digit slot
//
// Optional build macro: LEADING_ZERO_BLANK_EN turns off leading zero digits.
module disp_scan #(
    parameter int DIGITS       = 4,
    parameter int SLOT_CYCLES  = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [3:0]            nibble_out,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  load_ack,
    output logic                  frame_tick
);

    localparam int CW = $clog2(SLOT_CYCLES);
    localparam int IW = $clog2(DIGITS);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

    state_t                r_state, w_state_nxt;
    logic [CW-1:0]         r_cnt;
    logic [IW-1:0]         r_idx, w_idx_nxt;
    logic                  r_pending;
    logic [4*DIGITS-1:0]   r_pbuf_nib, r_disp_nib, w_disp_nib_nxt;
    logic [DIGITS-1:0]     r_pbuf_dp, r_disp_dp, w_disp_dp_nxt;
    logic [3:0]            r_nib;
    logic                  r_dp;
    logic                  r_ack;
    logic                  w_slot_end, w_frame_tick, w_commit, w_blank_entry;
    logic                  w_supp;

    assign w_slot_end    = (r_state == S_SHOW) && (r_cnt == SLOT_LAST);
    assign w_frame_tick  = enable && w_slot_end && (r_idx == IDX_LAST);
    assign w_commit      = r_pending && (w_frame_tick || r_state == S_IDLE);
    assign w_blank_entry = enable && (r_state == S_IDLE || w_slot_end);

    // Display contents as they will be after this edge. Using this value for
    // the nibble picked at blank entry lets digit 0 of the new frame show
    // freshly committed data.
    assign w_disp_nib_nxt = w_commit ? r_pbuf_nib : r_disp_nib;
    assign w_disp_dp_nxt  = w_commit ? r_pbuf_dp  : r_disp_dp;

    always_comb begin
        w_idx_nxt = r_idx;
        if (!enable || r_state == S_IDLE)
            w_idx_nxt = '0;
        else if (w_slot_end)
            w_idx_nxt = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        if (!enable)
            w_state_nxt = S_IDLE;
        else begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_BLANK;
                S_BLANK: if (r_cnt == BLANK_LAST) w_state_nxt = S_SHOW;
                S_SHOW:  if (r_cnt == SLOT_LAST)  w_state_nxt = S_BLANK;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        digit_en   = '0;
        if (r_state == S_SHOW && !w_supp)
            digit_en = {{(DIGITS-1){1'b0}}, 1'b1} << r_idx;
        frame_tick = w_frame_tick;
        nibble_out = r_nib;
        dp_out     = r_dp;
        load_ack   = r_ack;
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is dark when it and every higher digit has nibble 0 and no dp.
    // Digit 0 is never dark. The display registers change only at the frame
    // boundary, so this pattern holds steady for the whole frame.
    logic [DIGITS-1:0] w_lz;
    logic              w_run;
    always_comb begin
        w_lz  = '0;
        w_run = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            w_run   = w_run && (r_disp_nib[4*k +: 4] == 4'd0) && !r_disp_dp[k];
            w_lz[k] = w_run;
        end
    end
    assign w_supp = w_lz[r_idx];
`else
    assign w_supp = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            r_pending  <= 1'b0;
            r_pbuf_nib <= '0;
            r_pbuf_dp  <= '0;
            r_disp_nib <= '0;
            r_disp_dp  <= '0;
            r_nib      <= '0;
            r_dp       <= 1'b0;
            r_ack      <= 1'b0;
        end else begin
            if (!enable || r_state == S_IDLE || w_slot_end) r_cnt <= '0;
            else                                             r_cnt <= r_cnt + 1'b1;
            r_idx <= w_idx_nxt;

            // A load in a commit cycle wins over the clear, so it stays pending.
            if (load) begin
                r_pbuf_nib <= data_in;
                r_pbuf_dp  <= dp_in;
                r_pending  <= 1'b1;
            end else if (w_commit) begin
                r_pending  <= 1'b0;
            end

            r_disp_nib <= w_disp_nib_nxt;
            r_disp_dp  <= w_disp_dp_nxt;
            r_ack      <= w_commit;

            if (w_blank_entry) begin
                r_nib <= w_disp_nib_nxt[{w_idx_nxt, 2'b00} +: 4];
                r_dp  <= w_disp_dp_nxt[w_idx_nxt];
            end
        end
    end

endmodule

// File: tb/tb_disp_scan.sv
module tb_disp_scan;

    logic        clk = 1'b0;
    logic        rst_n, enable, load;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic [3:0]  nibble_out;
    logic        dp_out;
    logic [3:0]  digit_en;
    logic        load_ack, frame_tick;

    int checks = 0;
    int errors = 0;
    int pos    = 0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    typedef struct {
        logic [3:0] en;
        logic [3:0] nib;
        logic       dp;
        logic       ft;
        logic       ack;
    } exp_t;

    exp_t q[$];

    disp_scan #(.DIGITS(4), .SLOT_CYCLES(8), .BLANK_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
        .data_in(data_in), .dp_in(dp_in), .nibble_out(nibble_out),
        .dp_out(dp_out), .digit_en(digit_en), .load_ack(load_ack),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit dark(input logic [15:0] d, input logic [3:0] dpv, input int s);
        if (!LZ || s == 0) return 1'b0;
        for (int k = s; k < 4; k++)
            if (d[4*k +: 4] != 4'd0 || dpv[k]) return 1'b0;
        return 1'b1;
    endfunction

    // One expected scan cycle at slot position pos (8-cycle slots, 2 blank).
    task automatic push_cyc(input logic [15:0] d, input logic [3:0] dpv, input logic ack);
        exp_t e;
        int s, p;
        s = (pos / 8) % 4;
        p = pos % 8;
        e.nib = d[4*s +: 4];
        e.dp  = dpv[s];
        e.ft  = (s == 3 && p == 7);
        e.en  = (p >= 2 && !dark(d, dpv, s)) ? 4'(1 << s) : 4'd0;
        e.ack = ack;
        q.push_back(e);
        pos++;
    endtask

    task automatic push_frames(input int n, input logic [15:0] d, input logic [3:0] dpv, input logic ack_first);
        for (int i = 0; i < n; i++) push_cyc(d, dpv, ack_first && i == 0);
    endtask

    task automatic push_idle(input logic [3:0] nib, input logic dp, input logic ack);
        exp_t e;
        e.en = 4'd0; e.nib = nib; e.dp = dp; e.ft = 1'b0; e.ack = ack;
        q.push_back(e);
    endtask

    task automatic run(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (q.size() == 0) begin
                chk("queue_empty", 8'd1, 8'd0);
            end else begin
                e = q.pop_front();
                chk("digit_en",   8'(digit_en),   8'(e.en));
                chk("nibble_out", 8'(nibble_out), 8'(e.nib));
                chk("dp_out",     8'(dp_out),     8'(e.dp));
                chk("frame_tick", 8'(frame_tick), 8'(e.ft));
                chk("load_ack",   8'(load_ack),   8'(e.ack));
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_en"},  8'(digit_en),   8'd0);
        chk({tag, "_nib"}, 8'(nibble_out), 8'd0);
        chk({tag, "_dp"},  8'(dp_out),     8'd0);
        chk({tag, "_ack"}, 8'(load_ack),   8'd0);
        chk({tag, "_ft"},  8'(frame_tick), 8'd0);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; load = 1'b0; data_in = '0; dp_in = '0;
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        push_idle(4'd0, 1'b0, 1'b0);
        push_idle(4'd0, 1'b0, 1'b0);
        run(2);

        // Plain scan of blank display, two frames.
        enable = 1'b1;
        pos = 0;
        push_frames(64, 16'h0000, 4'h0, 1'b0);
        run(64);

        // Frame-aligned commits, last-wins overwrite, load during commit.
        push_frames(32, 16'h0000, 4'h0, 1'b0);
        push_frames(32, 16'h1234, 4'h2, 1'b1);
        push_frames(32, 16'h2222, 4'h0, 1'b1);
        push_frames(32, 16'h3333, 4'h0, 1'b1);
        push_frames(32, 16'h4444, 4'h0, 1'b1);
        run(10);
        load = 1'b1; data_in = 16'h1234; dp_in = 4'h2;
        run(1);  load = 1'b0;
        run(26);
        load = 1'b1; data_in = 16'h1111; dp_in = 4'h0;
        run(1);  load = 1'b0;
        run(8);
        load = 1'b1; data_in = 16'h2222; dp_in = 4'h0;
        run(1);  load = 1'b0;
        run(29);
        load = 1'b1; data_in = 16'h3333;
        run(1);  load = 1'b0;
        run(19);
        load = 1'b1; data_in = 16'h4444;   // sampled on the frame_tick edge
        run(1);  load = 1'b0;
        run(63);

        // Drop enable mid-show of digit 2, then restart.
        push_frames(21, 16'h4444, 4'h0, 1'b0);
        run(21);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) push_idle(4'h4, 1'b0, 1'b0);
        run(5);
        enable = 1'b1;
        pos = 0;
        push_frames(11, 16'h4444, 4'h0, 1'b0);
        run(4);
        load = 1'b1; data_in = 16'h5555;
        run(1);  load = 1'b0;
        run(6);

        // Async reset mid-show with data pending.
        #2 rst_n = 1'b0;
        #1 chk_zero("async_rst");
        q.delete();
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) push_idle(4'h0, 1'b0, 1'b0);
        run(20);

        // Idle commit of 0x0050, then scan for leading-zero behaviour.
        load = 1'b1; data_in = 16'h0050; dp_in = 4'h0;
        push_idle(4'h0, 1'b0, 1'b0);
        push_idle(4'h0, 1'b0, 1'b1);
        push_idle(4'h0, 1'b0, 1'b0);
        run(1);  load = 1'b0;
        run(2);
        enable = 1'b1;
        pos = 0;
        push_frames(64, 16'h0050, 4'h0, 1'b0);
        run(64);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
